axi_txn_engine: RTL and testbench
=================================

Name: axi_txn_engine

Overview:
- AXI4-Lite master that services the control unit's off-chip memory requests. It sits between the control unit and the PS/DDR AXI port.
- On `axi_txn_en` with `axi_sm_mode` = LOAD, it reads one 128-bit word as four 32-bit beats, returns it on `din` and pulses `inst_done`.
- With mode WRITE, it splits the 128-bit `uin` word into four 32-bit write beats, then pulses `inst_done`.
- Off-chip addresses come from internal auto-incrementing read and write pointers.

Parameters:
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h4000_0000, base byte address of the off-chip tensor region.
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.
- DIN_BITS, 128, control-unit word width.
- OFFMEM_BYTES, 4096, region size in bytes; power of two; pointers wrap modulo this.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- axi_sm_mode  in  2  00 IDLE, 01 LOAD_OFF_MEM_DATA, 10 WRITE_OFF_MEM_DATA, 11 reserved
- axi_txn_en  in  1  request strobe; held high by the control unit until `inst_done`
- uin  in  128  write data, sampled at transaction start
- din  out  128  assembled read data; valid while `inst_done`=1
- inst_done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag (bad response or reserved mode)
- err_clr  in  1  clears `err`
- ptr_clr  in  1  resets both pointers to 0; honoured only in IDLE
- M_AXI_AWADDR  out  32  write address
- M_AXI_AWPROT  out  3  constant 3'b000
- M_AXI_AWVALID  out  1  write address valid
- M_AXI_AWREADY  in  1  write address ready
- M_AXI_WDATA  out  32  write data
- M_AXI_WSTRB  out  4  constant 4'hF
- M_AXI_WVALID  out  1  write data valid
- M_AXI_WREADY  in  1  write data ready
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  write response valid
- M_AXI_BREADY  out  1  write response ready
- M_AXI_ARADDR  out  32  read address
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARVALID  out  1  read address valid
- M_AXI_ARREADY  in  1  read address ready
- M_AXI_RDATA  in  32  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID  in  1  read data valid
- M_AXI_RREADY  out  1  read data ready

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high): state=IDLE; all VALID/READY outputs 0; `din`=0; `inst_done`=0; `err`=0; `rd_ptr`=`wr_ptr`=0; beat counter=0.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE.
- IDLE:
  - `axi_txn_en`=1 and mode=01: latch address, beat=0, go to RD_AR.
  - mode=10: latch `uin` into `wbuf`, go to WR_AW_W.
  - mode=00 or 11 with `axi_txn_en`=1: set `err`, go to DONE. This prevents a control-unit deadlock.
- Beat address: beat k (k=0..3) addresses C_M_TARGET_SLAVE_BASE_ADDR + ptr + 4k.
- Beat data: beat k carries word bits [32k+31:32k] (little-endian beat order).
- WR_AW_W:
  - AWVALID and WVALID assert together.
  - Each deasserts independently on its own VALID&READY handshake.
  - When both have handshaken, assert BREADY and go to WR_B.
  - VALID, ADDR and DATA must stay stable until accepted.
- WR_B:
  - On BVALID&BREADY: drop BREADY; OR `err` with (BRESP != 00).
  - If beat==3 go to DONE; otherwise beat++ and return to WR_AW_W.
- RD_AR:
  - ARVALID=1; on handshake drop ARVALID, raise RREADY, go to RD_R.
- RD_R:
  - On RVALID&RREADY: store RDATA into lane `beat`; OR `err` with (RRESP != 00); drop RREADY.
  - If beat==3 go to DONE; otherwise beat++ and return to RD_AR.
- DONE:
  - `inst_done`=1 for exactly one cycle; `din` holds the assembled word.
  - The completed pointer advances by 16 modulo OFFMEM_BYTES (LOAD → `rd_ptr`, WRITE → `wr_ptr`).
  - Next state is always IDLE.
  - A new request is accepted no earlier than the cycle after DONE. The control unit deasserts `axi_txn_en` during `inst_done`, so a fresh assertion starts a new transaction.
- At most one outstanding transaction; the engine never issues concurrent reads and writes.
- Minimum latency, request to `inst_done`, with zero-wait slave:
  - write: 1 + 4×2 + 1 = 10 cycles.
  - read: 1 + 4×2 + 1 = 10 cycles.
- `axi_sm_mode` and `uin` changes mid-transaction are ignored.
- `axi_txn_en` dropping mid-transaction is ignored; the transaction runs to completion (AXI forbids abandoning VALID).
- Reset mid-transaction returns to IDLE immediately; the slave is expected to be reset by the same domain.
- `ptr_clr` outside IDLE is ignored.
- If `err_clr` and a new error occur in the same cycle, the error wins.
- Pointer wrap: a pointer at OFFMEM_BYTES-16 advances to 0.

Decomposition:
- Shared include `sa_share.v` gets:
  - the mode encodings (IDLE/LOAD_OFF_MEM_DATA/WRITE_OFF_MEM_DATA) currently local to the control unit, so both ends share them;
  - the AXI response codes OKAY=2'b00 and SLVERR=2'b10.
- The FSM is kept local to the module.
- One natural sub-module, `axi_lite_beat_ctr`: beat counter plus lane mux/demux between the 128-bit word and the 32-bit bus.

Test Plan:
- LOAD with zero-wait slave; memory words at 0x4000_0000.. = 11111111, 22222222, 33333333, 44444444 → ARADDR sequence 0x4000_0000/04/08/0C; `din`=128'h44444444_33333333_22222222_11111111; `inst_done` 1 cycle at cycle 10; `rd_ptr`=16.
- WRITE `uin`=128'hDDDD_CCCC_BBBB_AAAA_… → WDATA beats lane0..3 in order; AWREADY delayed 3 cycles while WREADY is immediate → AWADDR and AWVALID held stable until accepted; exactly 4 B handshakes; `wr_ptr`=16.
- Back-to-back LOADs with `rd_ptr` at 4080 → second request uses addresses base+4080.., then `rd_ptr` wraps to 0.
- Slave returns RRESP=SLVERR on beat 2 → transaction still completes, `err`=1 and sticky; `err_clr` → `err`=0.
- `axi_txn_en` with mode=11 → no AXI activity; `inst_done` pulses 2 cycles after request; `err`=1.
- `reset` asserted during RD_R → next cycle all VALID/READY outputs=0, state IDLE, `inst_done`=0.

Source files
------------

// File: rtl/axi_txn_engine_pkg.sv
// Shared encodings for the control unit <-> AXI transaction engine boundary:
// request modes, AXI response codes and the engine's FSM state constants.
package axi_txn_engine_pkg;

  // Request modes driven by the control unit on axi_sm_mode
  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Engine FSM states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_AW_W = 3'd1;
  localparam logic [2:0] ST_WR_B    = 3'd2;
  localparam logic [2:0] ST_RD_AR   = 3'd3;
  localparam logic [2:0] ST_RD_R    = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/axi_lite_beat_ctr.sv
// Beat counter plus lane mux/demux between the wide control-unit word and
// the 32-bit AXI data bus. Beat k maps to word bits [32k+31:32k].
module axi_lite_beat_ctr #(
  parameter  int DIN_BITS = 128,
  parameter  int DATA_W   = 32,
  localparam int BEATS    = DIN_BITS / DATA_W,
  localparam int BEAT_W   = $clog2(BEATS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                advance_i,
  input  logic                wr_load_i,
  input  logic [DIN_BITS-1:0] wr_word_i,
  input  logic                rd_store_i,
  input  logic [DATA_W-1:0]   rd_data_i,
  output logic [BEAT_W-1:0]   beat_o,
  output logic                last_o,
  output logic [DATA_W-1:0]   wr_next_lane_o,
  output logic [DIN_BITS-1:0] rd_word_o
);

  logic [BEAT_W-1:0]   beat_q;
  logic [BEAT_W-1:0]   next_beat;
  logic [DIN_BITS-1:0] wbuf_q;
  logic [DIN_BITS-1:0] rbuf_q;

  assign next_beat      = beat_q + BEAT_W'(1);
  assign beat_o         = beat_q;
  assign last_o         = (beat_q == BEAT_W'(BEATS - 1));
  assign wr_next_lane_o = wbuf_q[int'(next_beat) * DATA_W +: DATA_W];
  assign rd_word_o      = rbuf_q;

  // Track the current beat, hold the write word and assemble read lanes
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
      wbuf_q <= '0;
      rbuf_q <= '0;
    end else begin
      if (start_i)
        beat_q <= '0;
      else if (advance_i)
        beat_q <= next_beat;
      if (wr_load_i)
        wbuf_q <= wr_word_i;
      if (rd_store_i)
        rbuf_q[int'(beat_q) * DATA_W +: DATA_W] <= rd_data_i;
    end
  end

endmodule

// File: rtl/axi_txn_engine.sv
// AXI4-Lite master servicing the control unit's off-chip requests: a LOAD
// reads one wide word as four 32-bit beats, a WRITE stores one wide word as
// four beats. Addresses come from auto-incrementing read/write pointers.
module axi_txn_engine
  import axi_txn_engine_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH         = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int                            C_M_AXI_DATA_WIDTH         = 32,
  parameter int                            DIN_BITS                   = 128,
  parameter int                            OFFMEM_BYTES               = 4096
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      axi_sm_mode,
  input  logic                            axi_txn_en,
  input  logic [DIN_BITS-1:0]             uin,
  output logic [DIN_BITS-1:0]             din,
  output logic                            inst_done,
  output logic                            err,
  input  logic                            err_clr,
  input  logic                            ptr_clr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW     = C_M_AXI_ADDR_WIDTH;
  localparam int DW     = C_M_AXI_DATA_WIDTH;
  localparam int PTR_W  = $clog2(OFFMEM_BYTES);
  localparam int BEAT_W = $clog2(DIN_BITS / DW);
  localparam logic [AW-1:0]    BEAT_BYTES = AW'(DW / 8);
  localparam logic [PTR_W-1:0] WORD_BYTES = PTR_W'(DIN_BITS / 8);

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q;
  logic             awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [AW-1:0]    awaddr_q, araddr_q;
  logic [DW-1:0]    wdata_q;
  logic             inst_done_q, err_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W-1:0] rd_base, wr_base;

  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic             aw_done, w_done;
  logic             beat_start, beat_advance, wr_load, rd_store;
  logic [BEAT_W-1:0] beat;
  logic             beat_last;
  logic [DW-1:0]    wr_next_lane;

  assign aw_hs   = awvalid_q & M_AXI_AWREADY;
  assign w_hs    = wvalid_q  & M_AXI_WREADY;
  assign b_hs    = bready_q  & M_AXI_BVALID;
  assign ar_hs   = arvalid_q & M_AXI_ARREADY;
  assign r_hs    = rready_q  & M_AXI_RVALID;
  assign aw_done = ~awvalid_q | M_AXI_AWREADY;
  assign w_done  = ~wvalid_q  | M_AXI_WREADY;

  // A pointer clear arriving together with a request applies to that request
  assign rd_base = ptr_clr ? '0 : rd_ptr_q;
  assign wr_base = ptr_clr ? '0 : wr_ptr_q;

  assign beat_start   = (state_q == ST_IDLE) && (state_d != ST_IDLE);
  assign wr_load      = (state_q == ST_IDLE) && (state_d == ST_WR_AW_W);
  assign rd_store     = (state_q == ST_RD_R) && r_hs;
  assign beat_advance = ((state_q == ST_WR_B) && b_hs && !beat_last) ||
                        ((state_q == ST_RD_R) && r_hs && !beat_last);

  axi_lite_beat_ctr #(
    .DIN_BITS (DIN_BITS),
    .DATA_W   (DW)
  ) u_beat_ctr (
    .clk            (clk),
    .reset          (reset),
    .start_i        (beat_start),
    .advance_i      (beat_advance),
    .wr_load_i      (wr_load),
    .wr_word_i      (uin),
    .rd_store_i     (rd_store),
    .rd_data_i      (M_AXI_RDATA),
    .beat_o         (beat),
    .last_o         (beat_last),
    .wr_next_lane_o (wr_next_lane),
    .rd_word_o      (din)
  );

  // Next-state logic; IDLE ignores the request during the completion pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (axi_txn_en && !inst_done_q) begin
          if (axi_sm_mode == MODE_LOAD)       state_d = ST_RD_AR;
          else if (axi_sm_mode == MODE_WRITE) state_d = ST_WR_AW_W;
          else                                state_d = ST_DONE;
        end
      end
      ST_WR_AW_W: if (aw_done && w_done) state_d = ST_WR_B;
      ST_WR_B:    if (b_hs) state_d = beat_last ? ST_DONE : ST_WR_AW_W;
      ST_RD_AR:   if (ar_hs) state_d = ST_RD_R;
      ST_RD_R:    if (r_hs) state_d = beat_last ? ST_DONE : ST_RD_AR;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Registered AXI channel control, pointers, error flag and completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= MODE_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      inst_done_q <= 1'b0;
      err_q       <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      inst_done_q <= (state_q == ST_DONE);
      if (err_clr)
        err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ptr_clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
          end
          if (state_d != ST_IDLE)
            op_q <= axi_sm_mode;
          if (state_d == ST_RD_AR) begin
            arvalid_q <= 1'b1;
            araddr_q  <= C_M_TARGET_SLAVE_BASE_ADDR + AW'(rd_base);
          end else if (state_d == ST_WR_AW_W) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= C_M_TARGET_SLAVE_BASE_ADDR + AW'(wr_base);
            wdata_q   <= uin[DW-1:0];
          end else if (state_d == ST_DONE) begin
            err_q <= 1'b1;
          end
        end
        ST_WR_AW_W: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if (state_d == ST_WR_B) bready_q <= 1'b1;
        end
        ST_WR_B: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            if (M_AXI_BRESP != RESP_OKAY) err_q <= 1'b1;
            if (!beat_last) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              awaddr_q  <= awaddr_q + BEAT_BYTES;
              wdata_q   <= wr_next_lane;
            end
          end
        end
        ST_RD_AR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        ST_RD_R: begin
          if (r_hs) begin
            rready_q <= 1'b0;
            if (M_AXI_RRESP != RESP_OKAY) err_q <= 1'b1;
            if (!beat_last) begin
              arvalid_q <= 1'b1;
              araddr_q  <= araddr_q + BEAT_BYTES;
            end
          end
        end
        ST_DONE: begin
          if (op_q == MODE_LOAD)  rd_ptr_q <= rd_ptr_q + WORD_BYTES;
          if (op_q == MODE_WRITE) wr_ptr_q <= wr_ptr_q + WORD_BYTES;
        end
        default: ;
      endcase
    end
  end

  assign inst_done     = inst_done_q;
  assign err           = err_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_txn_engine.sv
// Bench for axi_txn_engine: a reactive AXI4-Lite slave with programmable
// ready delays and error injection, plus a word-level reference model of
// memory, pointers and the sticky error flag.
module tb_axi_txn_engine;
  import axi_txn_engine_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   axi_sm_mode = 2'b00;
  logic         axi_txn_en = 1'b0;
  logic [127:0] uin = '0;
  logic [127:0] din;
  logic         inst_done, err;
  logic         err_clr = 1'b0;
  logic         ptr_clr = 1'b0;
  logic [31:0]  M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]   M_AXI_WSTRB;
  logic         M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic         M_AXI_AWREADY = 1'b0;
  logic         M_AXI_WREADY  = 1'b0;
  logic         M_AXI_ARREADY = 1'b0;
  logic         M_AXI_BVALID  = 1'b0;
  logic         M_AXI_RVALID  = 1'b0;
  logic [1:0]   M_AXI_BRESP   = 2'b00;
  logic [1:0]   M_AXI_RRESP   = 2'b00;
  logic [31:0]  M_AXI_RDATA   = '0;

  always #5 clk = ~clk;

  axi_txn_engine dut (
    .clk(clk), .reset(reset), .axi_sm_mode(axi_sm_mode), .axi_txn_en(axi_txn_en),
    .uin(uin), .din(din), .inst_done(inst_done), .err(err), .err_clr(err_clr),
    .ptr_clr(ptr_clr),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int total = 0;
  int bad   = 0;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Power-on contents of the off-chip region (first four words are directed values)
  function automatic logic [31:0] initWord(input int idx);
    if (idx < 4) return 32'(idx + 1) * 32'h1111_1111;
    return (32'(idx) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- slave model ----------------
  logic [31:0] slvMem [1024];
  bit          slvWritten [1024];
  int          awDelay = 0, wDelay = 0, arDelay = 0;
  int          rErrBeat = -1, bErrBeat = -1;
  logic [31:0] arAddrQ[$], awAddrQ[$], wDataQ[$];
  int          bHsCount = 0;

  // Slave reacts to each edge: samples handshakes pre-edge, updates 1 time unit later
  always @(posedge clk) begin : slave
    logic rstS, awHs, wHs, bHs, arHs, rHs;
    logic [31:0] aA, wd, arA, off;
    logic awPend, wPend, arPend, awGot, wGot;
    logic [31:0] prevAw, prevW, prevAr, awA, wD;
    int awCnt, wCnt, arCnt, rBeat, bBeat;
    rstS = reset;
    awHs = M_AXI_AWVALID && M_AXI_AWREADY;
    wHs  = M_AXI_WVALID  && M_AXI_WREADY;
    bHs  = M_AXI_BVALID  && M_AXI_BREADY;
    arHs = M_AXI_ARVALID && M_AXI_ARREADY;
    rHs  = M_AXI_RVALID  && M_AXI_RREADY;
    aA = M_AXI_AWADDR; wd = M_AXI_WDATA; arA = M_AXI_ARADDR;
    if (!rstS) begin
      if (awPend) checkOutput("awHold", 128'({M_AXI_AWVALID, aA}), 128'({1'b1, prevAw}));
      if (wPend)  checkOutput("wHold",  128'({M_AXI_WVALID, wd}),  128'({1'b1, prevW}));
      if (arPend) checkOutput("arHold", 128'({M_AXI_ARVALID, arA}), 128'({1'b1, prevAr}));
      awPend = M_AXI_AWVALID && !M_AXI_AWREADY; prevAw = aA;
      wPend  = M_AXI_WVALID  && !M_AXI_WREADY;  prevW  = wd;
      arPend = M_AXI_ARVALID && !M_AXI_ARREADY; prevAr = arA;
    end else begin
      awPend = 1'b0; wPend = 1'b0; arPend = 1'b0;
    end
    #1;
    if (rstS) begin
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
      M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
      awGot = 1'b0; wGot = 1'b0; rBeat = 0; bBeat = 0;
      awCnt = 0; wCnt = 0; arCnt = 0;
    end else begin
      if (rHs) M_AXI_RVALID = 1'b0;
      if (bHs) begin M_AXI_BVALID = 1'b0; bHsCount++; end
      if (awHs) begin awGot = 1'b1; awA = aA; end
      if (wHs)  begin wGot = 1'b1; wD = wd; end
      if (awGot && wGot) begin
        off = awA - BASE;
        slvMem[off[11:2]] = wD;
        slvWritten[off[11:2]] = 1'b1;
        awAddrQ.push_back(awA);
        wDataQ.push_back(wD);
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = (bBeat == bErrBeat) ? RESP_SLVERR : RESP_OKAY;
        bBeat = (bBeat + 1) % 4;
        awGot = 1'b0; wGot = 1'b0;
      end
      if (arHs) begin
        off = arA - BASE;
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = slvWritten[off[11:2]] ? slvMem[off[11:2]] : initWord(int'(off[11:2]));
        M_AXI_RRESP  = (rBeat == rErrBeat) ? RESP_SLVERR : RESP_OKAY;
        rBeat = (rBeat + 1) % 4;
        arAddrQ.push_back(arA);
      end
      if (M_AXI_AWVALID) awCnt++; else awCnt = 0;
      if (M_AXI_WVALID)  wCnt++;  else wCnt = 0;
      if (M_AXI_ARVALID) arCnt++; else arCnt = 0;
      M_AXI_AWREADY = M_AXI_AWVALID && (awCnt > awDelay);
      M_AXI_WREADY  = M_AXI_WVALID  && (wCnt > wDelay);
      M_AXI_ARREADY = M_AXI_ARVALID && (arCnt > arDelay);
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] refMem [1024];
  int          rdPtr = 0, wrPtr = 0;
  bit          errM = 1'b0;

  // Issue one request, wait for completion and compare against the model
  task automatic applyStimulus(input logic [1:0] mode, input logic [127:0] u, input int expLat);
    int cyc, ar0, aw0, b0, idx;
    bit seen;
    logic [127:0] expDin;
    logic [31:0] got;
    ar0 = arAddrQ.size(); aw0 = awAddrQ.size(); b0 = bHsCount;
    axi_sm_mode = mode; uin = u; axi_txn_en = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (inst_done) seen = 1'b1;
    end
    axi_txn_en = 1'b0;
    axi_sm_mode = 2'($urandom);
    uin = {$urandom, $urandom, $urandom, $urandom};
    checkOutput("doneSeen", 128'(seen), 128'(1));
    if (expLat > 0) checkOutput("latency", 128'(cyc), 128'(expLat));
    if (mode == MODE_LOAD) begin
      for (int k = 0; k < 4; k++) begin
        idx = ar0 + k;
        got = (idx < arAddrQ.size()) ? arAddrQ[idx] : 32'hDEAD_BEEF;
        checkOutput("araddr", 128'(got), 128'(BASE + 32'(rdPtr) + 32'(4 * k)));
        expDin[32 * k +: 32] = refMem[(rdPtr >> 2) + k];
      end
      checkOutput("din", din, expDin);
      if (rErrBeat >= 0) errM = 1'b1;
      rdPtr = (rdPtr + 16) % 4096;
    end else if (mode == MODE_WRITE) begin
      for (int k = 0; k < 4; k++) begin
        idx = aw0 + k;
        got = (idx < awAddrQ.size()) ? awAddrQ[idx] : 32'hDEAD_BEEF;
        checkOutput("awaddr", 128'(got), 128'(BASE + 32'(wrPtr) + 32'(4 * k)));
        got = (idx < wDataQ.size()) ? wDataQ[idx] : 32'hDEAD_BEEF;
        checkOutput("wdata", 128'(got), 128'(u[32 * k +: 32]));
        refMem[(wrPtr >> 2) + k] = u[32 * k +: 32];
      end
      checkOutput("bCount", 128'(bHsCount - b0), 128'(4));
      if (bErrBeat >= 0) errM = 1'b1;
      wrPtr = (wrPtr + 16) % 4096;
    end else begin
      checkOutput("noAxi", 128'({32'(arAddrQ.size() - ar0), 32'(awAddrQ.size() - aw0)}), 128'(0));
      errM = 1'b1;
    end
    checkOutput("err", 128'(err), 128'(errM));
    @(posedge clk); #1;
    checkOutput("doneOnce", 128'(inst_done), 128'(0));
  endtask

  task automatic errClear();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    errM = 1'b0;
    checkOutput("errClr", 128'(err), 128'(0));
  endtask

  task automatic ptrClear();
    ptr_clr = 1'b1;
    @(posedge clk); #1;
    ptr_clr = 1'b0;
    rdPtr = 0; wrPtr = 0;
  endtask

  // Directed scenarios followed by a randomized mix
  initial begin
    int cyc, pick, lat;
    logic [1:0] mode;
    for (int i = 0; i < 1024; i++) refMem[i] = initWord(i);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOut", 128'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                                  M_AXI_RREADY, inst_done, err}), 128'(0));
    checkOutput("resetDin", din, 128'(0));
    reset = 1'b0;
    checkOutput("consts", 128'({M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}), 128'({3'b0, 3'b0, 4'hF}));

    // zero-wait LOAD of the first word
    applyStimulus(MODE_LOAD, '0, 10);
    checkOutput("dirDin", din, 128'h44444444_33333333_22222222_11111111);

    // WRITE with AWREADY held off for three cycles
    awDelay = 3;
    applyStimulus(MODE_WRITE, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, -1);
    awDelay = 0;

    // SLVERR on read beat 2, then stickiness, then clear
    rErrBeat = 2;
    applyStimulus(MODE_LOAD, '0, 10);
    rErrBeat = -1;
    applyStimulus(MODE_LOAD, '0, 10);
    errClear();

    // reserved and idle modes complete quickly with an error and no bus activity
    applyStimulus(2'b11, '0, 2);
    errClear();
    applyStimulus(MODE_IDLE, '0, 2);
    errClear();

    // walk the read pointer to the top of the region and wrap
    ptrClear();
    for (int n = 0; n < 255; n++) applyStimulus(MODE_LOAD, '0, 10);
    checkOutput("rdPtrTop", 128'(rdPtr), 128'(4080));
    applyStimulus(MODE_LOAD, '0, 10);
    applyStimulus(MODE_LOAD, '0, 10);

    // randomized mix of delays, modes, errors, pointer and error clears
    for (int n = 0; n < 80; n++) begin
      awDelay = $urandom_range(0, 3);
      wDelay  = $urandom_range(0, 3);
      arDelay = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) awDelay = 0;
      pick = $urandom_range(0, 19);
      if (pick == 0) ptrClear();
      if (pick == 1) errClear();
      pick = $urandom_range(0, 9);
      if (pick == 0)      mode = ($urandom_range(0, 1) == 0) ? 2'b11 : MODE_IDLE;
      else if (pick < 5)  mode = MODE_LOAD;
      else                mode = MODE_WRITE;
      if ($urandom_range(0, 7) == 0) begin
        if (mode == MODE_LOAD)  rErrBeat = $urandom_range(0, 3);
        if (mode == MODE_WRITE) bErrBeat = $urandom_range(0, 3);
      end
      if (mode != MODE_LOAD && mode != MODE_WRITE) lat = 2;
      else if (awDelay == 0 && wDelay == 0 && arDelay == 0) lat = 10;
      else lat = -1;
      applyStimulus(mode, {$urandom, $urandom, $urandom, $urandom}, lat);
      rErrBeat = -1;
      bErrBeat = -1;
    end
    awDelay = 0; wDelay = 0; arDelay = 0;

    // reset while waiting for read data
    axi_sm_mode = MODE_LOAD;
    axi_txn_en = 1'b1;
    cyc = 0;
    while (!M_AXI_RREADY && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("reachRdR", 128'(M_AXI_RREADY), 128'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstMid", 128'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                                M_AXI_RREADY, inst_done, err}), 128'(0));
    axi_txn_en = 1'b0;
    reset = 1'b0;
    rdPtr = 0; wrPtr = 0; errM = 1'b0;
    applyStimulus(MODE_LOAD, '0, 10);
    applyStimulus(MODE_WRITE, {$urandom, $urandom, $urandom, $urandom}, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
